// File: rtl/pipeline_run_control.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_run_control
//  Description : Execution sequencer for the 5-stage MIPS pipeline. Runs the
//                pipeline continuously or one cycle per STEP. It detects the
//                HALT opcode at fetch, freezes the PC, drains the in-flight
//                instructions and then reports done. It also counts the
//                enabled cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_run_control #(
  parameter int DATA_WIDTH   = 32,
  parameter int SIZEOP       = 6,
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_instruccion,
  input  logic                  i_cmd_valid,
  input  logic [1:0]            i_cmd,
  output logic                  o_cmd_ready,
  output logic                  o_pipe_en,
  output logic                  o_pc_en,
  output logic                  o_halt_seen,
  output logic                  o_done,
  output logic [CNT_WIDTH-1:0]  o_cycle_count
);

  localparam logic [SIZEOP-1:0] c_op_halt     = {SIZEOP{1'b1}};
  localparam logic [3:0]        c_drain_init  = DRAIN_CYCLES[3:0];
  localparam logic [1:0]        c_cmd_run     = 2'b00;
  localparam logic [1:0]        c_cmd_step    = 2'b01;
  localparam logic [1:0]        c_cmd_pause   = 2'b10;
  localparam logic [1:0]        c_cmd_clear   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  halt_seen_q, halt_seen_d;
  logic [3:0]            drain_cnt_q, drain_cnt_d;
  logic [CNT_WIDTH-1:0]  cycle_cnt_q, cycle_cnt_d;

  logic [SIZEOP-1:0]     w_opcode;
  logic                  w_is_halt;
  logic                  w_cmd_acc;
  logic                  w_unused;

  // Only the opcode field matters here; the rest of the word is deliberately dropped.
  assign w_opcode  = i_instruccion[DATA_WIDTH-1 -: SIZEOP];
  assign w_unused  = ^i_instruccion[DATA_WIDTH-SIZEOP-1:0];
  assign w_is_halt = (w_opcode == c_op_halt);

  assign o_pipe_en     = (state_q == RUN) || (state_q == STEP);
  assign o_pc_en       = o_pipe_en && !halt_seen_q && !w_is_halt;
  assign o_done        = (state_q == DONE);
  assign o_cmd_ready   = (state_q != STEP);
  assign o_halt_seen   = halt_seen_q;
  assign o_cycle_count = cycle_cnt_q;
  assign w_cmd_acc     = i_cmd_valid && o_cmd_ready;

  // State, halt/drain tracking and cycle counter registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= IDLE;
      halt_seen_q <= 1'b0;
      drain_cnt_q <= 4'd0;
      cycle_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      halt_seen_q <= halt_seen_d;
      drain_cnt_q <= drain_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  // Next-state: command handling first, then halt/drain overrides on enabled cycles.
  always_comb begin
    state_d     = state_q;
    halt_seen_d = halt_seen_q;
    drain_cnt_d = drain_cnt_q;
    cycle_cnt_d = cycle_cnt_q;

    // Saturating count of enabled cycles.
    if (o_pipe_en && (cycle_cnt_q != {CNT_WIDTH{1'b1}})) begin
      cycle_cnt_d = cycle_cnt_q + CNT_WIDTH'(1);
    end

    case (state_q)
      IDLE: begin
        if (w_cmd_acc) begin
          case (i_cmd)
            c_cmd_run:   state_d = RUN;
            c_cmd_step:  state_d = STEP;
            c_cmd_clear: begin
              halt_seen_d = 1'b0;
              drain_cnt_d = 4'd0;
              cycle_cnt_d = '0;
            end
            default:     state_d = IDLE;
          endcase
        end
      end
      RUN: begin
        if (w_cmd_acc && (i_cmd == c_cmd_pause)) begin
          state_d = IDLE;
        end
      end
      STEP: begin
        state_d = IDLE;
      end
      DONE: begin
        if (w_cmd_acc && (i_cmd == c_cmd_clear)) begin
          state_d     = IDLE;
          halt_seen_d = 1'b0;
          drain_cnt_d = 4'd0;
          cycle_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // HALT capture and drain countdown take priority over PAUSE and STEP return.
    if (o_pipe_en) begin
      if (!halt_seen_q) begin
        if (w_is_halt) begin
          halt_seen_d = 1'b1;
          drain_cnt_d = c_drain_init;
          if (c_drain_init == 4'd0) begin
            state_d = DONE;
          end
        end
      end else begin
        if (drain_cnt_q != 4'd0) begin
          drain_cnt_d = drain_cnt_q - 4'd1;
        end
        if (drain_cnt_q == 4'd1) begin
          state_d = DONE;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_run_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_run_control
//  Description : Self-checking bench for pipeline_run_control. A table of
//                per-cycle input/expected-output records is replayed, and a
//                few hand-written multi-cycle sequences cover the corner
//                cases, including an asynchronous reset during the drain.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_run_control;

  localparam logic [1:0]  RUN_C   = 2'b00;
  localparam logic [1:0]  STEP_C  = 2'b01;
  localparam logic [1:0]  PAUSE_C = 2'b10;
  localparam logic [1:0]  CLEAR_C = 2'b11;
  localparam logic [31:0] NOP     = 32'h0000_0000;
  localparam logic [31:0] HALT    = 32'hFC00_0000;

  typedef struct {
    logic        valid;
    logic [1:0]  cmd;
    logic [31:0] instr;
    logic        pe;
    logic        pce;
    logic        hs;
    logic        dn;
    logic        rdy;
    logic [31:0] cnt;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        cmd_valid;
  logic [1:0]  cmd;
  logic        cmd_ready;
  logic        pipe_en;
  logic        pc_en;
  logic        halt_seen;
  logic        done;
  logic [31:0] cycle_count;

  int   n_cmp;
  int   n_err;
  vec_t tbl[$];
  vec_t exp_q[$];

  pipeline_run_control #(
    .DATA_WIDTH  (32),
    .SIZEOP      (6),
    .DRAIN_CYCLES(4),
    .CNT_WIDTH   (32)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_instruccion(instr),
    .i_cmd_valid  (cmd_valid),
    .i_cmd        (cmd),
    .o_cmd_ready  (cmd_ready),
    .o_pipe_en    (pipe_en),
    .o_pc_en      (pc_en),
    .o_halt_seen  (halt_seen),
    .o_done       (done),
    .o_cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void add(input logic v, input logic [1:0] c, input logic [31:0] ins,
                              input logic pe, input logic pce, input logic hs,
                              input logic dn, input logic rdy, input int cnt);
    vec_t t;
    t.valid = v;  t.cmd = c;  t.instr = ins;
    t.pe = pe;    t.pce = pce; t.hs = hs; t.dn = dn; t.rdy = rdy;
    t.cnt = 32'(cnt);
    tbl.push_back(t);
  endfunction

  // Compare current DUT outputs against one expected record.
  task automatic check(input string name, input vec_t e);
    logic [4:0] act_f, exp_f;
    act_f = {pipe_en, pc_en, halt_seen, done, cmd_ready};
    exp_f = {e.pe, e.pce, e.hs, e.dn, e.rdy};
    n_cmp++;
    if (act_f !== exp_f) begin
      n_err++;
      $display("FAIL %s flags{pe,pce,hs,dn,rdy}: got %b expected %b", name, act_f, exp_f);
    end
    n_cmp++;
    if (cycle_count !== e.cnt) begin
      n_err++;
      $display("FAIL %s cycle_count: got %0d expected %0d", name, cycle_count, e.cnt);
    end
  endtask

  // Drive one record after the rising edge, score it mid-cycle on the falling edge.
  task automatic apply(input string name, input vec_t t);
    vec_t e;
    @(posedge clk);
    #1;
    cmd_valid = t.valid;
    cmd       = t.cmd;
    instr     = t.instr;
    exp_q.push_back(t);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s scoreboard: got empty queue expected entry", name);
    end else begin
      e = exp_q.pop_front();
      check(name, e);
    end
  endtask

  initial begin
    vec_t r;
    n_cmp = 0;
    n_err = 0;
    cmd_valid = 1'b0;
    cmd = RUN_C;
    instr = NOP;
    rst = 1'b1;

    // ---------------- table construction ----------------
    // Idle after reset, PAUSE in IDLE ignored.
    for (int i = 0; i < 5; i++) add(0, RUN_C, NOP, 0,0,0,0,1, 0);
    add(1, PAUSE_C, NOP, 0,0,0,0,1, 0);
    add(0, RUN_C,   NOP, 0,0,0,0,1, 0);
    // RUN for 10 cycles (CLEAR ignored in RUN), PAUSE cycle still enabled.
    add(1, RUN_C, NOP, 0,0,0,0,1, 0);
    for (int i = 0; i < 10; i++) add((i == 4), CLEAR_C, NOP, 1,1,0,0,1, i);
    add(1, PAUSE_C, NOP, 1,1,0,0,1, 10);
    add(0, RUN_C,   NOP, 0,0,0,0,1, 11);
    add(1, CLEAR_C, NOP, 0,0,0,0,1, 11);
    add(0, RUN_C,   NOP, 0,0,0,0,1, 0);
    // RUN with HALT as third enabled cycle; opcode ignored during drain.
    add(1, RUN_C, NOP,  0,0,0,0,1, 0);
    add(0, RUN_C, NOP,  1,1,0,0,1, 0);
    add(0, RUN_C, NOP,  1,1,0,0,1, 1);
    add(0, RUN_C, HALT, 1,0,0,0,1, 2);
    for (int k = 0; k < 4; k++) add(0, RUN_C, (k == 1) ? HALT : NOP, 1,0,1,0,1, 3 + k);
    add(0, RUN_C,   NOP, 0,0,1,1,1, 7);
    add(1, RUN_C,   NOP, 0,0,1,1,1, 7);
    add(0, RUN_C,   NOP, 0,0,1,1,1, 7);
    add(1, CLEAR_C, NOP, 0,0,1,1,1, 7);
    add(0, RUN_C,   NOP, 0,0,0,0,1, 0);
    // STEP mode: HALT on 2nd step, four drain steps, commands refused while stepping.
    add(1, STEP_C, NOP,  0,0,0,0,1, 0);
    add(1, RUN_C,  NOP,  1,1,0,0,0, 0);
    add(1, STEP_C, NOP,  0,0,0,0,1, 1);
    add(0, RUN_C,  HALT, 1,0,0,0,0, 1);
    for (int k = 0; k < 4; k++) begin
      add(1, STEP_C, NOP, 0,0,1,0,1, 2 + k);
      add(0, RUN_C,  NOP, 1,0,1,0,0, 2 + k);
    end
    add(0, RUN_C,   NOP, 0,0,1,1,1, 6);
    add(1, CLEAR_C, NOP, 0,0,1,1,1, 6);
    add(0, RUN_C,   NOP, 0,0,0,0,1, 0);
    // HALT in the same cycle as an accepted PAUSE, then RUN drains to DONE.
    add(1, RUN_C,   NOP,  0,0,0,0,1, 0);
    add(0, RUN_C,   NOP,  1,1,0,0,1, 0);
    add(1, PAUSE_C, HALT, 1,0,0,0,1, 1);
    add(0, RUN_C,   NOP,  0,0,1,0,1, 2);
    add(1, RUN_C,   NOP,  0,0,1,0,1, 2);
    for (int k = 0; k < 4; k++) add(0, RUN_C, NOP, 1,0,1,0,1, 2 + k);
    add(0, RUN_C,   NOP, 0,0,1,1,1, 6);
    add(1, CLEAR_C, NOP, 0,0,1,1,1, 6);
    add(0, RUN_C,   NOP, 0,0,0,0,1, 0);
    // Pause mid-drain keeps the drain count; RUN resumes it.
    add(1, RUN_C,   NOP,  0,0,0,0,1, 0);
    add(0, RUN_C,   NOP,  1,1,0,0,1, 0);
    add(0, RUN_C,   HALT, 1,0,0,0,1, 1);
    add(1, PAUSE_C, NOP,  1,0,1,0,1, 2);
    add(0, RUN_C,   NOP,  0,0,1,0,1, 3);
    add(1, RUN_C,   NOP,  0,0,1,0,1, 3);
    for (int k = 0; k < 3; k++) add(0, RUN_C, NOP, 1,0,1,0,1, 3 + k);
    add(0, RUN_C,   NOP, 0,0,1,1,1, 6);

    // ---------------- reset state ----------------
    #12;
    r.pe = 0; r.pce = 0; r.hs = 0; r.dn = 0; r.rdy = 1; r.cnt = 0;
    r.valid = 0; r.cmd = RUN_C; r.instr = NOP;
    check("reset_hold", r);
    rst = 1'b0;

    // ---------------- table replay ----------------
    for (int i = 0; i < tbl.size(); i++) apply($sformatf("vec%0d", i), tbl[i]);

    // ---------------- asynchronous reset mid-drain ----------------
    r.valid = 1; r.cmd = CLEAR_C; r.instr = NOP;
    r.pe = 0; r.pce = 0; r.hs = 1; r.dn = 1; r.rdy = 1; r.cnt = 6;
    apply("ar_clear", r);
    r.valid = 1; r.cmd = RUN_C; r.hs = 0; r.dn = 0; r.cnt = 0;
    apply("ar_run", r);
    r.valid = 0; r.pe = 1; r.pce = 0; r.instr = HALT;
    apply("ar_halt", r);
    r.instr = NOP; r.hs = 1; r.cnt = 1;
    apply("ar_drain", r);
    #2;
    rst = 1'b1;
    #1;
    r.pe = 0; r.pce = 0; r.hs = 0; r.dn = 0; r.rdy = 1; r.cnt = 0;
    check("ar_async", r);
    #1;
    rst = 1'b0;
    r.valid = 0; r.cmd = RUN_C; r.instr = NOP;
    apply("ar_after", r);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
